// File: rtl/execute_pkg.sv
// Shared Execute-stage definitions: controller state encodings, slice width
// and the signed saturation limits used by the nibble-serial add/sub unit.
package execute_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int unsigned NIBBLE_W = 4;

    // Saturation limits for a given width (up to 64 bits); callers keep the low bits.
    function automatic logic [63:0] sat_max_pos(input int unsigned width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_max_neg(input int unsigned width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/addsub_nibble_slice.sv
// 4-bit ripple adder slice with exposed carry-in; c3 is the carry into the
// top bit so the caller can derive signed overflow as c3 ^ cout.
module addsub_nibble_slice
    import execute_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout,
    output logic                c3
);

    logic [NIBBLE_W:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end

    assign cout = carry[NIBBLE_W];
    assign c3   = carry[NIBBLE_W-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder, the ripple cell of the nibble slice.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (cin & (a ^ b));
    end

endmodule

// File: rtl/nibble_serial_addsub_ctrl.sv
// Multi-cycle WIDTH-bit add/sub controller: one nibble per clock, LSB first,
// with registered carry, start/done handshake and final flag computation.
module nibble_serial_addsub_ctrl
    import execute_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             sat,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovfl,
    output logic             zero,
    output logic             neg
);

    localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
    localparam int unsigned CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int unsigned IDX_W   = CNT_W + 2;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);
    localparam logic [WIDTH-1:0] MAX_POS  = WIDTH'(sat_max_pos(WIDTH));
    localparam logic [WIDTH-1:0] MAX_NEG  = WIDTH'(sat_max_neg(WIDTH));

    logic [1:0]          state_q;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic                sat_q;
    logic                carry_q;
    logic [CNT_W-1:0]    cnt_q;

    logic [IDX_W-1:0]    base;
    logic [NIBBLE_W-1:0] a_nib;
    logic [NIBBLE_W-1:0] b_nib;
    logic [NIBBLE_W-1:0] sum_nib;
    logic                slice_cout;
    logic                slice_c3;
    logic [WIDTH-1:0]    raw_full;
    logic [WIDTH-1:0]    final_res;
    logic                final_ovfl;

    addsub_nibble_slice u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_q),
        .sum  (sum_nib),
        .cout (slice_cout),
        .c3   (slice_c3)
    );

    always_comb begin
        base     = {cnt_q, 2'b00};
        a_nib    = a_q[base +: NIBBLE_W];
        b_nib    = b_q[base +: NIBBLE_W];
        raw_full = result;
        raw_full[base +: NIBBLE_W] = sum_nib;
        // On the last nibble bit 3 is the MSB, so c3 ^ cout equals the
        // operand-sign overflow test (equal input signs, differing result sign).
        final_ovfl = slice_c3 ^ slice_cout;
        if (sat_q && final_ovfl) begin
            final_res = a_q[WIDTH-1] ? MAX_NEG : MAX_POS;
        end else begin
            final_res = raw_full;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sat_q   <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            result  <= '0;
            cout    <= 1'b0;
            ovfl    <= 1'b0;
            zero    <= 1'b0;
            neg     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        sat_q   <= sat;
                        carry_q <= sub;
                        cnt_q   <= '0;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    carry_q <= slice_cout;
                    if (cnt_q == LAST_CNT) begin
                        result  <= final_res;
                        cout    <= slice_cout;
                        ovfl    <= final_ovfl;
                        zero    <= (final_res == '0);
                        neg     <= final_res[WIDTH-1];
                        cnt_q   <= '0;
                        state_q <= ST_DONE;
                    end else begin
                        result  <= raw_full;
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        busy = (state_q != ST_IDLE);
        done = (state_q == ST_DONE);
    end

endmodule
